// File: rtl/decoder_pkg.sv
// Shared RV32I decode types: opcodes, control encodings and the registered control bundle.
package decoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    result_src_e result_src;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src;
    logic        alu_a_pc;
    logic        jalr;
    logic        jal;
    logic        branch;
    alu_ctrl_e   alu_control;
    imm_sel_e    imm_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } ctrl_bundle_t;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I decoder: raw instruction word to control bundle.
module decode_logic
  import decoder_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       f3_ok;
  logic [5:0] unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7b5        = instr[30];
  assign unused_bits = {instr[31], instr[29:25]};

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = f3;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    f3_ok       = 1'b1;
    case (opcode)
      OP_LOAD: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        f3_ok           = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_S;
        f3_ok          = (f3 < 3'b011);
      end
      OP_OP: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_from_f3(f3, f7b5);
      end
      OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        // funct7 only exists for shifts; ADDI uses those bits as immediate.
        ctrl.alu_control = alu_from_f3(f3, f7b5 && (f3 == 3'b101));
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.imm_sel     = IMM_B;
        f3_ok            = (f3[2:1] != 2'b01);
      end
      OP_JAL: begin
        ctrl.jal        = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_sel    = IMM_J;
      end
      OP_JALR: begin
        ctrl.jalr       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src    = 1'b1;
        f3_ok           = (f3 == 3'b000);
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_PASS_B;
        ctrl.imm_sel     = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_pc  = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Illegal slots still flow down the pipe but must have no side effects.
    if (!f3_ok) begin
      ctrl.illegal   = 1'b1;
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jal       = 1'b0;
      ctrl.jalr      = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, flush, branch resolution, decoded counter.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit FULL_BRANCH = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            equal,
  input  logic            less_than,
  input  logic            less_than_unsigned,
  output logic [1:0]      result_src,
  output logic            mem_write,
  output logic            reg_write,
  output logic            alu_src,
  output logic            alu_a_pc,
  output logic            jalr,
  output logic [3:0]      alu_control,
  output logic [2:0]      immediate_control,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal,
  output logic            pc_src,
  output logic [XLEN-1:0] decoded_count
);

  ctrl_bundle_t    dec;
  ctrl_bundle_t    bundle_d, bundle_q;
  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] count_d, count_q;
  logic            capture, handshake, cond;

  decode_logic u_decode (.instr(instruction), .ctrl(dec));

  assign in_ready  = !out_valid_q || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign handshake = out_valid_q && out_ready && !flush;

  always_comb begin
    bundle_d    = capture ? dec : bundle_q;
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (capture)   out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    count_d = handshake ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  // Legacy mode only honours BEQ; other B-type conditions never redirect.
  always_comb begin
    cond = 1'b0;
    case (bundle_q.funct3)
      3'b000:  cond = equal;
      3'b001:  cond = !equal;
      3'b100:  cond = less_than;
      3'b101:  cond = !less_than;
      3'b110:  cond = less_than_unsigned;
      3'b111:  cond = !less_than_unsigned;
      default: cond = 1'b0;
    endcase
    if (!FULL_BRANCH) cond = (bundle_q.funct3 == 3'b000) && equal;
  end

  assign pc_src = out_valid_q &&
                  ((bundle_q.branch && cond) || bundle_q.jal || bundle_q.jalr);

  assign out_valid         = out_valid_q;
  assign result_src        = bundle_q.result_src;
  assign mem_write         = bundle_q.mem_write;
  assign reg_write         = bundle_q.reg_write;
  assign alu_src           = bundle_q.alu_src;
  assign alu_a_pc          = bundle_q.alu_a_pc;
  assign jalr              = bundle_q.jalr;
  assign alu_control       = bundle_q.alu_control;
  assign immediate_control = bundle_q.imm_sel;
  assign rd                = bundle_q.rd;
  assign rs1               = bundle_q.rs1;
  assign rs2               = bundle_q.rs2;
  assign illegal           = bundle_q.illegal;
  assign decoded_count     = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: full-branch 32-bit instance plus a legacy 4-bit-counter instance.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready, equal, less_than, less_than_unsigned;
  logic [31:0] instruction;

  logic        in_ready, out_valid, mem_write, reg_write, alu_src, alu_a_pc, jalr, illegal, pc_src;
  logic [1:0]  result_src;
  logic [3:0]  alu_control;
  logic [2:0]  immediate_control;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] decoded_count;

  logic        l_in_ready, l_out_valid, l_mem_write, l_reg_write, l_alu_src, l_alu_a_pc, l_jalr, l_illegal, l_pc_src;
  logic [1:0]  l_result_src;
  logic [3:0]  l_alu_control;
  logic [2:0]  l_immediate_control;
  logic [4:0]  l_rd, l_rs1, l_rs2;
  logic [3:0]  l_decoded_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FULL_BRANCH(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .equal(equal), .less_than(less_than), .less_than_unsigned(less_than_unsigned),
    .result_src(result_src), .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
    .alu_a_pc(alu_a_pc), .jalr(jalr), .alu_control(alu_control),
    .immediate_control(immediate_control), .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal(illegal), .pc_src(pc_src), .decoded_count(decoded_count)
  );

  decode_stage #(.XLEN(4), .FULL_BRANCH(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .instruction(instruction), .flush(flush), .out_valid(l_out_valid), .out_ready(out_ready),
    .equal(equal), .less_than(less_than), .less_than_unsigned(less_than_unsigned),
    .result_src(l_result_src), .mem_write(l_mem_write), .reg_write(l_reg_write), .alu_src(l_alu_src),
    .alu_a_pc(l_alu_a_pc), .jalr(l_jalr), .alu_control(l_alu_control),
    .immediate_control(l_immediate_control), .rd(l_rd), .rs1(l_rs1), .rs2(l_rs2),
    .illegal(l_illegal), .pc_src(l_pc_src), .decoded_count(l_decoded_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        eq, lt, ltu;
    logic [14:0] ctrl;
    logic        pc, pc_l;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl[NV];
  int checks = 0;
  int errors = 0;

  // {result_src, mem_write, reg_write, alu_src, alu_a_pc, jalr, alu_control, imm, illegal}
  function automatic logic [14:0] c(input logic [1:0] rs, input logic [4:0] bits,
                                    input logic [3:0] alu, input logic [2:0] imm, input logic ill);
    return {rs, bits, alu, imm, ill};
  endfunction

  function automatic vec_t v(input string n, input logic [31:0] i, input logic eq, input logic lt,
                             input logic ltu, input logic [14:0] ct, input logic p, input logic pl);
    vec_t r;
    r.name = n; r.instr = i; r.eq = eq; r.lt = lt; r.ltu = ltu; r.ctrl = ct; r.pc = p; r.pc_l = pl;
    return r;
  endfunction

  function automatic logic [14:0] got_ctrl();
    return {result_src, mem_write, reg_write, alu_src, alu_a_pc, jalr,
            alu_control, immediate_control, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v("add",      32'h002081B3, 0, 0, 0, c(2'b00, 5'b01000, 4'b0000, 3'b000, 0), 0, 0);
    tbl[1]  = v("sub",      32'h402081B3, 0, 0, 0, c(2'b00, 5'b01000, 4'b0001, 3'b000, 0), 0, 0);
    tbl[2]  = v("lw",       32'h0000A283, 0, 0, 0, c(2'b01, 5'b01100, 4'b0000, 3'b000, 0), 0, 0);
    tbl[3]  = v("sw",       32'h0020A223, 0, 0, 0, c(2'b00, 5'b10100, 4'b0000, 3'b001, 0), 0, 0);
    tbl[4]  = v("beq_eq",   32'h00208063, 1, 0, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 1, 1);
    tbl[5]  = v("bne_ne",   32'h00209063, 0, 0, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 1, 0);
    tbl[6]  = v("blt_lt",   32'h0020C063, 0, 1, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 1, 0);
    tbl[7]  = v("bge_lt",   32'h0020D063, 0, 1, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 0, 0);
    tbl[8]  = v("bltu_nl",  32'h0020E063, 0, 0, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 0, 0);
    tbl[9]  = v("bgeu_ltu", 32'h0020F063, 0, 0, 1, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 0, 0);
    tbl[10] = v("bne_eq",   32'h00209063, 1, 0, 0, c(2'b00, 5'b00000, 4'b0001, 3'b010, 0), 0, 0);
    tbl[11] = v("jal",      32'h000000EF, 0, 0, 0, c(2'b10, 5'b01000, 4'b0000, 3'b011, 0), 1, 1);
    tbl[12] = v("jalr",     32'h000100E7, 0, 0, 0, c(2'b10, 5'b01101, 4'b0000, 3'b000, 0), 1, 1);
    tbl[13] = v("lui",      32'h123452B7, 0, 0, 0, c(2'b00, 5'b01100, 4'b1010, 3'b100, 0), 0, 0);
    tbl[14] = v("auipc",    32'h00000297, 0, 0, 0, c(2'b00, 5'b01110, 4'b0000, 3'b100, 0), 0, 0);
    tbl[15] = v("addi_f7",  32'h40000093, 0, 0, 0, c(2'b00, 5'b01100, 4'b0000, 3'b000, 0), 0, 0);
    tbl[16] = v("srai",     32'h4030D093, 0, 0, 0, c(2'b00, 5'b01100, 4'b1001, 3'b000, 0), 0, 0);
    tbl[17] = v("sra",      32'h4020D1B3, 0, 0, 0, c(2'b00, 5'b01000, 4'b1001, 3'b000, 0), 0, 0);
    tbl[18] = v("and",      32'h0020F1B3, 0, 0, 0, c(2'b00, 5'b01000, 4'b0010, 3'b000, 0), 0, 0);
    tbl[19] = v("sltu",     32'h0020B1B3, 0, 0, 0, c(2'b00, 5'b01000, 4'b0110, 3'b000, 0), 0, 0);
    tbl[20] = v("ill_op0",  32'h00000000, 1, 1, 1, c(2'b00, 5'b00000, 4'b0000, 3'b000, 1), 0, 0);
    tbl[21] = v("ill_b010", 32'h0020A063, 1, 1, 1, c(2'b00, 5'b00000, 4'b0001, 3'b010, 1), 0, 0);
    tbl[22] = v("ill_jalr", 32'h000110E7, 1, 1, 1, c(2'b10, 5'b00100, 4'b0000, 3'b000, 1), 0, 0);

    reset = 1; in_valid = 0; flush = 0; out_ready = 0; instruction = '0;
    equal = 0; less_than = 0; less_than_unsigned = 0;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_count", decoded_count, 0);
    chk("rst_ctrl", {17'b0, got_ctrl()}, 0);
    chk("rst_pc_src", {31'b0, pc_src}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    reset = 0;

    // back-to-back add, sub
    instruction = 32'h002081B3; in_valid = 1; out_ready = 1;
    tick();
    chk("b2b_add_valid", {31'b0, out_valid}, 1);
    chk("b2b_add_alu", {28'b0, alu_control}, 32'h0);
    chk("b2b_add_regs", {17'b0, rd, rs1, rs2}, {17'b0, 5'd3, 5'd1, 5'd2});
    chk("b2b_in_ready", {31'b0, in_ready}, 1);
    instruction = 32'h402081B3;
    tick();
    chk("b2b_sub_alu", {28'b0, alu_control}, 32'h1);
    chk("b2b_cnt1", decoded_count, 1);
    in_valid = 0;
    tick();
    chk("b2b_drain_valid", {31'b0, out_valid}, 0);
    chk("b2b_cnt2", decoded_count, 2);

    // stall on lw, then flush with a simultaneous handshake
    instruction = 32'h0000A283; in_valid = 1; out_ready = 0;
    tick();
    chk("stall_in_ready", {31'b0, in_ready}, 0);
    chk("stall_res_src", {30'b0, result_src}, 32'h1);
    chk("stall_alu_src", {31'b0, alu_src}, 1);
    instruction = 32'h002081B3;
    tick();
    chk("stall_hold_res", {30'b0, result_src}, 32'h1);
    chk("stall_hold_rd", {27'b0, rd}, 5);
    chk("stall_hold_valid", {31'b0, out_valid}, 1);
    chk("stall_cnt", decoded_count, 2);
    flush = 1; out_ready = 1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_cnt", decoded_count, 2);
    chk("flush_cnt_l", {28'b0, l_decoded_count}, 2);
    flush = 0; in_valid = 0;
    tick();
    chk("flush_blocked_capture", {31'b0, out_valid}, 0);

    // table sweep, full throughput
    for (int i = 0; i < NV; i++) begin
      instruction = tbl[i].instr; in_valid = 1; out_ready = 1;
      equal = tbl[i].eq; less_than = tbl[i].lt; less_than_unsigned = tbl[i].ltu;
      tick();
      chk({tbl[i].name, "_ctrl"}, {17'b0, got_ctrl()}, {17'b0, tbl[i].ctrl});
      chk({tbl[i].name, "_pc_src"}, {31'b0, pc_src}, {31'b0, tbl[i].pc});
      chk({tbl[i].name, "_pc_src_legacy"}, {31'b0, l_pc_src}, {31'b0, tbl[i].pc_l});
    end
    in_valid = 0;
    tick();
    chk("sweep_cnt", decoded_count, 2 + NV);
    chk("sweep_cnt_l", {28'b0, l_decoded_count}, (2 + NV) % 16);

    // counter wrap on the 4-bit instance
    reset = 1;
    tick();
    reset = 0;
    instruction = 32'h00500093; in_valid = 1; out_ready = 1;
    repeat (16) tick();
    chk("wrap_cnt_15", {28'b0, l_decoded_count}, 15);
    in_valid = 0;
    tick();
    chk("wrap_cnt_0", {28'b0, l_decoded_count}, 0);
    chk("wrap_cnt_wide", decoded_count, 16);

    // reset while stalled on jal
    instruction = 32'h000000EF; in_valid = 1; out_ready = 0;
    tick();
    chk("jal_stall_pc_src", {31'b0, pc_src}, 1);
    in_valid = 0; reset = 1;
    tick();
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_pc_src", {31'b0, pc_src}, 0);
    chk("midrst_cnt", decoded_count, 0);
    chk("midrst_reg_write", {31'b0, reg_write}, 0);
    reset = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
